router_pkt_gen: RTL and testbench

- Packet source for the 1x3 router; drives the router input side (pkt_valid, data, busy back-pressure) and observes the router's err flag.
- Each commanded packet is sent as: header byte, LEN payload bytes, then one parity byte.
  - Header is {len[5:0], addr[1:0]}.
  - Payload bytes come from an internal 8-bit LFSR.
  - Parity is the XOR of the header and all payload bytes.
- Serves as the self-checking traffic source in router integration benches and on-chip loopback tests.

---
 rtl/router_pkt_gen.sv | 211 +++++++++++++++++++++
 tb/tb_router_pkt_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_gen.sv
// Packet source for the 1x3 router: sends header, LFSR payload and parity byte,
// honours busy back-pressure, then watches the router err flag for a fixed window.
module router_pkt_gen #(
  parameter logic [7:0] SEED     = 8'hA5,
  parameter int         ERR_WAIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pay_len,
  input  logic       corrupt_parity,
  input  logic       busy,
  input  logic       err,
  output logic       cmd_ready,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_active,
  output logic       done,
  output logic       bad_cmd,
  output logic [7:0] pkt_count,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PARITY  = 3'd3,
    S_CHECK   = 3'd4
  } state_t;

  localparam logic [3:0] LP_WAIT_LAST = 4'(ERR_WAIT - 1);

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [7:0] parity_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t     r_state, w_state_nxt;
  logic [7:0] r_lfsr, w_lfsr_nxt;
  logic [7:0] r_parity, w_parity_nxt;
  logic [5:0] r_cnt, w_cnt_nxt;
  logic [5:0] r_len, w_len_nxt;
  logic [1:0] r_addr, w_addr_nxt;
  logic       r_corrupt, w_corrupt_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic       r_pkt_valid, w_valid_nxt;
  logic       r_done, w_done_nxt;
  logic       r_bad_cmd, w_bad_nxt;
  logic [7:0] r_pkt_count, w_pkt_cnt_nxt;
  logic [7:0] r_err_count, w_err_cnt_nxt;
  logic [3:0] r_wait, w_wait_nxt;
  logic       r_err_flag, w_flag_nxt;
  logic       w_tx_active;
  logic       w_xfer;
  logic [7:0] w_par_final;

  assign w_tx_active = (r_state == S_HEADER) || (r_state == S_PAYLOAD) || (r_state == S_PARITY);
  assign w_xfer      = w_tx_active && !busy;
  assign w_par_final = parity_acc(r_parity, r_data);

  assign cmd_ready = (r_state == S_IDLE);
  assign tx_active = w_tx_active;
  assign pkt_valid = r_pkt_valid;
  assign data_out  = r_data;
  assign done      = r_done;
  assign bad_cmd   = r_bad_cmd;
  assign pkt_count = r_pkt_count;
  assign err_count = r_err_count;

  // Next-state and next-datapath values; every stalled byte simply keeps its defaults.
  always_comb begin
    w_state_nxt   = r_state;
    w_lfsr_nxt    = r_lfsr;
    w_parity_nxt  = r_parity;
    w_cnt_nxt     = r_cnt;
    w_len_nxt     = r_len;
    w_addr_nxt    = r_addr;
    w_corrupt_nxt = r_corrupt;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_pkt_valid;
    w_done_nxt    = 1'b0;
    w_bad_nxt     = 1'b0;
    w_pkt_cnt_nxt = r_pkt_count;
    w_err_cnt_nxt = r_err_count;
    w_wait_nxt    = r_wait;
    w_flag_nxt    = r_err_flag;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((dest_addr != 2'd3) && (pay_len != 6'd0)) begin
            w_len_nxt     = pay_len;
            w_addr_nxt    = dest_addr;
            w_corrupt_nxt = corrupt_parity;
            w_data_nxt    = {pay_len, dest_addr};
            w_valid_nxt   = 1'b1;
            w_state_nxt   = S_HEADER;
          end else begin
            w_bad_nxt = 1'b1;
          end
        end else begin
          w_bad_nxt = 1'b0;
        end
      end
      S_HEADER: begin
        if (w_xfer) begin
          w_parity_nxt = r_data;
          w_cnt_nxt    = 6'd0;
          w_data_nxt   = r_lfsr;
          w_state_nxt  = S_PAYLOAD;
        end else begin
          w_state_nxt = S_HEADER;
        end
      end
      S_PAYLOAD: begin
        if (w_xfer) begin
          w_parity_nxt = w_par_final;
          w_lfsr_nxt   = lfsr_next(r_lfsr);
          if (r_cnt == (r_len - 6'd1)) begin
            w_data_nxt  = r_corrupt ? ~w_par_final : w_par_final;
            w_valid_nxt = 1'b0;
            w_state_nxt = S_PARITY;
          end else begin
            w_data_nxt = lfsr_next(r_lfsr);
            w_cnt_nxt  = r_cnt + 6'd1;
          end
        end else begin
          w_state_nxt = S_PAYLOAD;
        end
      end
      S_PARITY: begin
        if (w_xfer) begin
          w_data_nxt  = 8'd0;
          w_wait_nxt  = 4'd0;
          w_state_nxt = S_CHECK;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
      S_CHECK: begin
        // busy is deliberately ignored here; only the err window matters.
        w_flag_nxt = r_err_flag | err;
        if (r_wait == LP_WAIT_LAST) begin
          w_done_nxt    = 1'b1;
          w_pkt_cnt_nxt = r_pkt_count + 8'd1;
          if ((r_err_flag | err) && (r_err_count != 8'hFF)) begin
            w_err_cnt_nxt = r_err_count + 8'd1;
          end else begin
            w_err_cnt_nxt = r_err_count;
          end
          w_flag_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_wait_nxt = r_wait + 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr      <= SEED;
      r_parity    <= 8'd0;
      r_cnt       <= 6'd0;
      r_len       <= 6'd0;
      r_addr      <= 2'd0;
      r_corrupt   <= 1'b0;
      r_data      <= 8'd0;
      r_pkt_valid <= 1'b0;
      r_done      <= 1'b0;
      r_bad_cmd   <= 1'b0;
      r_pkt_count <= 8'd0;
      r_err_count <= 8'd0;
      r_wait      <= 4'd0;
      r_err_flag  <= 1'b0;
    end else begin
      r_lfsr      <= w_lfsr_nxt;
      r_parity    <= w_parity_nxt;
      r_cnt       <= w_cnt_nxt;
      r_len       <= w_len_nxt;
      r_addr      <= w_addr_nxt;
      r_corrupt   <= w_corrupt_nxt;
      r_data      <= w_data_nxt;
      r_pkt_valid <= w_valid_nxt;
      r_done      <= w_done_nxt;
      r_bad_cmd   <= w_bad_nxt;
      r_pkt_count <= w_pkt_cnt_nxt;
      r_err_count <= w_err_cnt_nxt;
      r_wait      <= w_wait_nxt;
      r_err_flag  <= w_flag_nxt;
    end
  end

endmodule

// File: tb/tb_router_pkt_gen.sv
// Randomized bench for router_pkt_gen: a queue-based packet model predicts every
// transferred byte, the done timing and the packet/error counters.
module tb_router_pkt_gen;

  localparam int EW = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic [5:0] pay_len = 6'd0;
  logic       corrupt_parity = 1'b0;
  logic       busy = 1'b0;
  logic       err = 1'b0;
  logic       cmd_ready, pkt_valid, tx_active, done, bad_cmd;
  logic [7:0] data_out, pkt_count, err_count;

  int total = 0;
  int bad = 0;

  logic [7:0] m_lfsr = 8'hA5;
  logic [7:0] m_pkt = 8'd0;
  logic [7:0] m_err = 8'd0;
  logic [7:0] obs_q[$];
  int         plan_q[$];
  bit         rand_busy = 1'b0;
  int         cyc;

  router_pkt_gen dut (
    .clk(clk), .rst(rst), .start(start), .dest_addr(dest_addr), .pay_len(pay_len),
    .corrupt_parity(corrupt_parity), .busy(busy), .err(err), .cmd_ready(cmd_ready),
    .pkt_valid(pkt_valid), .data_out(data_out), .tx_active(tx_active), .done(done),
    .bad_cmd(bad_cmd), .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_step(input logic [7:0] q);
    logic nb;
    nb = ^(q & 8'hB8);
    return 8'((q << 1) | {7'd0, nb});
  endfunction

  // err_at: -1 never, -2 random, otherwise the index of the CHECK edge that sees err.
  task automatic run_pkt(input logic [1:0] a, input logic [5:0] n, input bit corrupt,
                         input int err_at, output int cycles);
    logic [7:0] exp_q[$];
    logic [7:0] par;
    bit b, e, errseen;
    int k;
    exp_q = {};
    exp_q.push_back({n, a});
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back(m_lfsr);
      m_lfsr = model_step(m_lfsr);
    end
    par = 8'd0;
    foreach (exp_q[i]) par = par ^ exp_q[i];
    exp_q.push_back(corrupt ? ~par : par);
    obs_q = {};
    start = 1'b1; dest_addr = a; pay_len = n; corrupt_parity = corrupt; busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; corrupt_parity = 1'b0;
    dest_addr = 2'($urandom); pay_len = 6'($urandom);
    k = 0; cycles = 0;
    while (k < int'(n) + 2 && cycles < 2000) begin
      check_val("tx_active", {31'd0, tx_active}, 32'd1);
      check_val("data_out", {24'd0, data_out}, {24'd0, exp_q[k]});
      check_val("pkt_valid", {31'd0, pkt_valid}, {31'd0, (k <= int'(n))});
      check_val("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      if (plan_q.size() > 0) b = (plan_q.pop_front() != 0);
      else b = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
      busy = b;
      err = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      if (!b) obs_q.push_back(data_out);
      @(posedge clk);
      if (!b) k++;
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 2000) check_val("tx_timeout", 32'd1, 32'd0);
    errseen = 1'b0;
    for (int i = 0; i < EW; i++) begin
      check_val("done_early", {31'd0, done}, 32'd0);
      check_val("tx_idle", {31'd0, tx_active}, 32'd0);
      check_val("valid_check", {31'd0, pkt_valid}, 32'd0);
      check_val("data_zero", {24'd0, data_out}, 32'd0);
      if (err_at == -2) e = ($urandom_range(0, 3) == 0);
      else e = (err_at == i);
      errseen = errseen | e;
      err = e; busy = 1'($urandom_range(0, 1)); start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    err = 1'b0; busy = 1'b0;
    m_pkt = m_pkt + 8'd1;
    if (errseen && m_err != 8'hFF) m_err = m_err + 8'd1;
    check_val("done", {31'd0, done}, 32'd1);
    check_val("cmd_ready_done", {31'd0, cmd_ready}, 32'd1);
    check_val("pkt_count", {24'd0, pkt_count}, {24'd0, m_pkt});
    check_val("err_count", {24'd0, err_count}, {24'd0, m_err});
    @(negedge clk);
    check_val("done_once", {31'd0, done}, 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_lfsr = 8'hA5; m_pkt = 8'd0; m_err = 8'd0;
    @(negedge clk);
  endtask

  task automatic check_test1_bytes(input logic [7:0] par);
    logic [7:0] ref_b[5];
    ref_b = '{8'h0D, 8'hA5, 8'h4A, 8'h95, par};
    check_val("t1_len", obs_q.size(), 32'd5);
    for (int i = 0; i < 5 && i < obs_q.size(); i++)
      check_val("t1_byte", {24'd0, obs_q[i]}, {24'd0, ref_b[i]});
  endtask

  task automatic illegal_cmd(input logic [1:0] a, input logic [5:0] n);
    start = 1'b1; dest_addr = a; pay_len = n;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_val("bad_cmd", {31'd0, bad_cmd}, 32'd1);
    check_val("bad_valid", {31'd0, pkt_valid}, 32'd0);
    check_val("bad_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("bad_tx", {31'd0, tx_active}, 32'd0);
    check_val("bad_pkts", {24'd0, pkt_count}, {24'd0, m_pkt});
    @(negedge clk);
    check_val("bad_cmd_once", {31'd0, bad_cmd}, 32'd0);
  endtask

  initial begin
    #2;
    check_val("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("rst_tx", {31'd0, tx_active}, 32'd0);
    check_val("rst_valid", {31'd0, pkt_valid}, 32'd0);
    check_val("rst_data", {24'd0, data_out}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_bad", {31'd0, bad_cmd}, 32'd0);
    check_val("rst_counts", {16'd0, pkt_count, err_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_pkt(2'd1, 6'd3, 1'b0, -1, cyc);
    check_test1_bytes(8'h77);
    check_val("t1_latency", cyc, 32'd8);

    run_pkt(2'd0, 6'd1, 1'b0, -1, cyc);
    check_val("t2_hdr", {24'd0, obs_q[0]}, 32'h04);
    check_val("t2_pay", {24'd0, obs_q[1]}, 32'h2A);
    check_val("t2_par", {24'd0, obs_q[2]}, 32'h2E);

    apply_reset();
    plan_q = {1, 1, 0, 0, 1};
    run_pkt(2'd1, 6'd3, 1'b0, -1, cyc);
    check_test1_bytes(8'h77);
    check_val("t3_latency", cyc, 32'd11);

    apply_reset();
    run_pkt(2'd1, 6'd3, 1'b1, 1, cyc);
    check_test1_bytes(8'h88);
    check_val("t4_err_count", {24'd0, err_count}, 32'd1);

    illegal_cmd(2'd3, 6'd5);
    illegal_cmd(2'd2, 6'd0);
    run_pkt(2'd2, 6'd2, 1'b0, -1, cyc);

    start = 1'b1; dest_addr = 2'd2; pay_len = 6'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("t6_valid_before", {31'd0, pkt_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_val("t6_valid_async", {31'd0, pkt_valid}, 32'd0);
    check_val("t6_data_async", {24'd0, data_out}, 32'd0);
    check_val("t6_counts", {16'd0, pkt_count, err_count}, 32'd0);
    check_val("t6_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) begin
      @(negedge clk);
      check_val("t6_no_done", {31'd0, done}, 32'd0);
    end
    rst = 1'b1;
    m_lfsr = 8'hA5; m_pkt = 8'd0; m_err = 8'd0;
    @(negedge clk);
    check_val("t6_no_done_after", {31'd0, done}, 32'd0);
    run_pkt(2'd0, 6'd2, 1'b0, -1, cyc);
    check_val("t6_first_payload", {24'd0, obs_q[1]}, 32'hA5);

    rand_busy = 1'b1;
    for (int p = 0; p < 300; p++) begin
      logic [5:0] n;
      int ea;
      n = ($urandom_range(0, 19) == 0) ? 6'd63 : 6'($urandom_range(1, 6));
      ea = ($urandom_range(0, 19) == 0) ? -2 : 0;
      run_pkt(2'($urandom_range(0, 2)), n, 1'($urandom_range(0, 1)), ea, cyc);
      if ($urandom_range(0, 29) == 0) illegal_cmd(2'd3, 6'($urandom_range(0, 63)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
